// File: rtl/breakout_sound_scheduler.sv
// ---------------------------------------------------------------------------
// breakout_sound_scheduler
// Latches one-cycle game sound-effect requests and plays the highest-priority
// pending effect on a single pin as a fixed-pitch square tone of fixed length.
// A silent gap follows every effect. The whole block runs in the CLK_40M domain.
//
// Ports
//   CLK_40M     in   system clock, rising edge
//   RESET       in   asynchronous, active-high; aborts any effect, drops requests
//   EV_WALL     in   one-cycle request, source 0 (lowest priority)
//   EV_PADDLE   in   one-cycle request, source 1
//   EV_BRICK    in   one-cycle request, source 2
//   EV_LOSE     in   one-cycle request, source 3 (highest priority)
//   MUTE        in   forces AUDIO_OUT low; sequencing is unaffected
//   AUDIO_OUT   out  registered square-wave output
//   BUSY        out  registered, high while playing or in the gap
//   ACTIVE_SRC  out  registered source being played, 0 outside of PLAY
// ---------------------------------------------------------------------------
module breakout_sound_scheduler #(
    parameter int unsigned TICK_DIV    = 40000,   // clocks per duration tick
    parameter int unsigned GAP_TICKS   = 20,      // silent ticks after an effect
    parameter int unsigned HALF_WALL   = 80000,   // tone half-periods in clocks
    parameter int unsigned HALF_PADDLE = 40000,
    parameter int unsigned HALF_BRICK  = 20000,
    parameter int unsigned HALF_LOSE   = 100000,
    parameter int unsigned DUR_WALL    = 30,      // effect lengths in ticks
    parameter int unsigned DUR_PADDLE  = 40,
    parameter int unsigned DUR_BRICK   = 50,
    parameter int unsigned DUR_LOSE    = 250
) (
    input  logic       CLK_40M,
    input  logic       RESET,
    input  logic       EV_WALL,
    input  logic       EV_PADDLE,
    input  logic       EV_BRICK,
    input  logic       EV_LOSE,
    input  logic       MUTE,
    output logic       AUDIO_OUT,
    output logic       BUSY,
    output logic [1:0] ACTIVE_SRC
);

    localparam int unsigned TICK_W = 16;
    localparam int unsigned HALF_W = 17;
    localparam int unsigned DUR_W  = 8;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned NSRC   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Registered state
    state_t              state;
    logic [NSRC-1:0]     pending;
    logic [HALF_W-1:0]   half_cnt;
    logic [TICK_W-1:0]   presc_cnt;
    logic [DUR_W-1:0]    tick_cnt;     // effect duration in PLAY, gap length in GAP
    logic                tone_phase;

    // Next-state values
    state_t              state_nxt;
    logic [NSRC-1:0]     pending_nxt;
    logic [HALF_W-1:0]   half_nxt;
    logic [TICK_W-1:0]   presc_nxt;
    logic [DUR_W-1:0]    tick_nxt;
    logic                phase_nxt;
    logic                audio_nxt;
    logic                busy_nxt;
    logic [SRC_W-1:0]    src_nxt;
    logic [NSRC-1:0]     grant_mask;
    logic [SRC_W-1:0]    grant_src;

    // Fixed priority: LOSE > BRICK > PADDLE > WALL
    function automatic logic [SRC_W-1:0] top_src(input logic [NSRC-1:0] p);
        logic [SRC_W-1:0] s;
        if (p[3])      s = SRC_W'(3);
        else if (p[2]) s = SRC_W'(2);
        else if (p[1]) s = SRC_W'(1);
        else           s = SRC_W'(0);
        return s;
    endfunction

    // Tone half-period per source
    function automatic logic [HALF_W-1:0] half_of(input logic [SRC_W-1:0] s);
        logic [HALF_W-1:0] h;
        case (s)
            2'd0:    h = HALF_W'(HALF_WALL);
            2'd1:    h = HALF_W'(HALF_PADDLE);
            2'd2:    h = HALF_W'(HALF_BRICK);
            default: h = HALF_W'(HALF_LOSE);
        endcase
        return h;
    endfunction

    // Effect duration in ticks per source
    function automatic logic [DUR_W-1:0] dur_of(input logic [SRC_W-1:0] s);
        logic [DUR_W-1:0] d;
        case (s)
            2'd0:    d = DUR_W'(DUR_WALL);
            2'd1:    d = DUR_W'(DUR_PADDLE);
            2'd2:    d = DUR_W'(DUR_BRICK);
            default: d = DUR_W'(DUR_LOSE);
        endcase
        return d;
    endfunction

    // Next-state, counter and output logic
    always_comb begin
        state_nxt  = state;
        half_nxt   = half_cnt;
        presc_nxt  = presc_cnt;
        tick_nxt   = tick_cnt;
        phase_nxt  = tone_phase;
        src_nxt    = ACTIVE_SRC;
        grant_mask = '0;
        grant_src  = top_src(pending);

        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    grant_mask = NSRC'(1) << grant_src;
                    state_nxt  = ST_PLAY;
                    src_nxt    = grant_src;
                    phase_nxt  = 1'b1;
                    half_nxt   = half_of(grant_src);
                    presc_nxt  = TICK_W'(TICK_DIV);
                    tick_nxt   = dur_of(grant_src);
                end
            end

            ST_PLAY: begin
                // Tone generator: toggle and reload when the half-period expires
                if (half_cnt == HALF_W'(1)) begin
                    phase_nxt = ~tone_phase;
                    half_nxt  = half_of(ACTIVE_SRC);
                end else begin
                    half_nxt  = half_cnt - HALF_W'(1);
                end
                // Duration: one tick per prescaler expiry; last tick ends the effect
                if (presc_cnt == TICK_W'(1)) begin
                    presc_nxt = TICK_W'(TICK_DIV);
                    if (tick_cnt == DUR_W'(1)) begin
                        state_nxt = ST_GAP;
                        phase_nxt = 1'b0;
                        src_nxt   = '0;
                        tick_nxt  = DUR_W'(GAP_TICKS);
                    end else begin
                        tick_nxt  = tick_cnt - DUR_W'(1);
                    end
                end else begin
                    presc_nxt = presc_cnt - TICK_W'(1);
                end
            end

            ST_GAP: begin
                phase_nxt = 1'b0;
                if (presc_cnt == TICK_W'(1)) begin
                    presc_nxt = TICK_W'(TICK_DIV);
                    if (tick_cnt == DUR_W'(1)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        tick_nxt  = tick_cnt - DUR_W'(1);
                    end
                end else begin
                    presc_nxt = presc_cnt - TICK_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = 1'b0;
                src_nxt   = '0;
            end
        endcase

        // A new request on the grant edge wins over the clear, so it replays later
        pending_nxt = (pending & ~grant_mask) | {EV_LOSE, EV_BRICK, EV_PADDLE, EV_WALL};
        busy_nxt    = (state_nxt != ST_IDLE);
        audio_nxt   = phase_nxt & ~MUTE;
    end

    // State and output registers
    always_ff @(posedge CLK_40M or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            pending    <= '0;
            half_cnt   <= '0;
            presc_cnt  <= '0;
            tick_cnt   <= '0;
            tone_phase <= 1'b0;
            AUDIO_OUT  <= 1'b0;
            BUSY       <= 1'b0;
            ACTIVE_SRC <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            half_cnt   <= half_nxt;
            presc_cnt  <= presc_nxt;
            tick_cnt   <= tick_nxt;
            tone_phase <= phase_nxt;
            AUDIO_OUT  <= audio_nxt;
            BUSY       <= busy_nxt;
            ACTIVE_SRC <= src_nxt;
        end
    end

endmodule

// File: doc/breakout_sound_scheduler.md
# breakout_sound_scheduler

Arbitrates the game's sound-effect requests onto the single AUDIO_OUT pin. Game logic raises one-cycle event pulses (wall, paddle, brick, ball lost). The block latches them, grants the highest-priority pending effect, and plays it as a square tone of fixed pitch and duration. A silent gap follows each effect. It sits between the game-state logic and the top-level AUDIO_OUT pad and runs entirely in the CLK_40M domain.

## Interface
- TICK_DIV, 40000: clocks per duration tick (1 ms at 40 MHz); 16 bit
- GAP_TICKS, 20: silent ticks after every effect; 8 bit, ≥1
- HALF_WALL / HALF_PADDLE / HALF_BRICK / HALF_LOSE, 80000 / 40000 / 20000 / 100000: tone half-period in clocks; 17 bit, ≥1
- DUR_WALL / DUR_PADDLE / DUR_BRICK / DUR_LOSE, 30 / 40 / 50 / 250: effect length in ticks; 8 bit, ≥1
- CLK_40M  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high
- EV_WALL  in  1  one-cycle request, source 0
- EV_PADDLE  in  1  one-cycle request, source 1
- EV_BRICK  in  1  one-cycle request, source 2
- EV_LOSE  in  1  one-cycle request, source 3
- MUTE  in  1  forces AUDIO_OUT low; sequencing continues
- AUDIO_OUT  out  1  registered square-wave output
- BUSY  out  1  high in PLAY or GAP
- ACTIVE_SRC  out  2  source being played; 0 when not in PLAY

## Operation
- Reset: pending[3:0]=0, state IDLE, all counters 0, AUDIO_OUT=0, BUSY=0, ACTIVE_SRC=0. Reset is asynchronous; assertion mid-effect aborts immediately and drops all pending requests.
- Pending latch:
  - EV_x high at a rising edge sets pending[x].
  - A grant clears the granted bit.
  - A set and a clear of the same bit on the same edge leave the bit set (request is replayed later).
  - Each source holds one pending entry; repeat pulses while pending are merged.
- Priority, highest first: LOSE(3) > BRICK(2) > PADDLE(1) > WALL(0). Fixed, no rotation. No preemption: a playing effect always completes.
- FSM states IDLE, PLAY, GAP:
  - IDLE: if any pending bit is set, grant the highest. Then:
    - state ← PLAY
    - ACTIVE_SRC ← source
    - AUDIO_OUT ← 1 (0 if MUTE)
    - half-period counter ← HALF_src
    - tick prescaler ← TICK_DIV
    - duration counter ← DUR_src
    - BUSY ← 1
  - PLAY:
    - Each clock the half-period counter decrements. When it reaches 1, the tone phase toggles and the counter reloads HALF_src.
    - Each clock the prescaler decrements. When it reaches 1, it reloads and the duration counter decrements.
    - When the duration counter reaches 1 and the prescaler reaches 1, go to GAP: AUDIO_OUT=0, ACTIVE_SRC=0, gap counter loaded with GAP_TICKS, prescaler reloaded.
  - GAP: AUDIO_OUT=0. Ticks count down. When the last tick expires, go to IDLE with BUSY=0. Requests arriving during PLAY or GAP are latched normally.
- AUDIO_OUT = tone_phase AND NOT MUTE, registered. MUTE takes effect one cycle after it is sampled.
- Counter arithmetic is unsigned, with no wrap: every load and compare uses values ≥1.

## Timing
- Event sampled at edge E:
  - pending set at E.
  - Grant at E+1 if IDLE, so AUDIO_OUT first rises after edge E+1.
  - Event-to-sound latency is 2 edges from a pulse asserted in the cycle before E.
- PLAY lasts exactly DUR_src×TICK_DIV clocks.
- AUDIO_OUT toggles every HALF_src clocks, starting high. Tone frequency = 40 MHz / (2×HALF_src).
- GAP lasts exactly GAP_TICKS×TICK_DIV clocks.
- The next grant occurs on the first edge in IDLE, so BUSY is low for at least 1 cycle between effects.
- Back-to-back sequence length: DUR×TICK_DIV + GAP_TICKS×TICK_DIV + 1 clocks per effect.

## Test plan
Bench parameters: TICK_DIV=4, GAP_TICKS=1, HALF_WALL=3, HALF_LOSE=2, DUR_WALL=2, DUR_LOSE=3; others 1/1.
- Single wall event: EV_WALL pulse at edge 10.
  - Grant at edge 11: ACTIVE_SRC=0, BUSY=1.
  - AUDIO_OUT runs 3 high / 3 low / 2 high for 8 clocks.
  - Then 4 clocks low with BUSY=1.
  - BUSY falls at edge 23.
- Simultaneous EV_WALL and EV_LOSE at the same edge:
  - LOSE plays first: 12 clocks, toggling every 2.
  - Then the gap (4 clocks), 1 IDLE cycle, and WALL plays.
- EV_LOSE during a WALL effect: WALL is not preempted; LOSE is granted on the first IDLE edge after the gap.
- Three EV_BRICK pulses during one PLAY: exactly one BRICK replay follows.
- MUTE held high across a full LOSE effect: AUDIO_OUT=0 throughout; BUSY and ACTIVE_SRC timing are unchanged.
- RESET asserted mid-PLAY with WALL pending:
  - AUDIO_OUT, BUSY and ACTIVE_SRC go to 0 asynchronously.
  - After release, nothing plays until a new event arrives.
